serial_port_router: RTL and testbench

- Parametrised N-port serial line router between the machine UART (core_tx/core_rx) and NUM_PORTS physical serial ports (console UART, USER_IO pins, future ports).
- Generalises the fixed two-way console/USER_IO selection:
  - any port count;
  - per-port input synchronisers;
  - per-port receive-enable outputs.
- Glitch-free switching: a new selection takes effect only after all involved lines have been idle for a programmable time, so no character is truncated mid-frame.
- Sits at the top level between the menu status bits and the altair machine serial pins.

---
 rtl/serial_port_router.sv | 116 +++++++++++
 tb/tb_serial_port_router.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port_router.sv
// N-port serial line router between the machine UART and the physical ports.
// Port changes wait for all involved lines to be idle, so no frame is cut mid-character.
module serial_port_router #(
   parameter int NUM_PORTS   = 2,
   parameter int SEL_W       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_CYCLES = 52083,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SEL_W-1:0]     sel_req,
   input  logic [NUM_PORTS-1:0] rx_in,
   output logic [NUM_PORTS-1:0] tx_out,
   output logic [NUM_PORTS-1:0] rx_en,
   input  logic                 core_tx,
   output logic                 core_rx,
   output logic [SEL_W-1:0]     sel_active,
   output logic                 switching
);

   typedef enum logic [1:0] {ACTIVE, PENDING, SWITCH} state_t;

   localparam logic [SEL_W:0]     NUM_PORTS_W = NUM_PORTS[SEL_W:0];
   localparam logic [CNT_W-1:0]   IDLE_MAX    = CNT_W'(IDLE_CYCLES);

   state_t                               state, state_nxt;
   logic [SYNC_STAGES-1:0][NUM_PORTS-1:0] sync_q;
   logic [NUM_PORTS-1:0]                 rxs;
   logic [CNT_W-1:0]                     idle_cnt;
   logic                                 req_ok;
   logic [SEL_W-1:0]                     target;
   logic                                 idle_ok;
   logic [SEL_W-1:0]                     sel_nxt;
   logic [NUM_PORTS-1:0]                 sel_oh_nxt;
   logic [NUM_PORTS-1:0]                 tx_nxt;
   logic                                 core_rx_nxt;

   // Synchronisers reset to the idle (mark) level so a reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= rx_in;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_q[s] <= sync_q[s-1];
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   // Out-of-range requests (non power-of-two port counts) collapse onto the current port.
   assign req_ok  = ({1'b0, sel_req} < NUM_PORTS_W);
   assign target  = req_ok ? sel_req : sel_active;
   assign idle_ok = rxs[sel_active] & rxs[target] & core_tx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         idle_cnt <= '0;
      else if (state != PENDING || !idle_ok)
         idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
         idle_cnt <= idle_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ACTIVE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_active;
      case (state)
         ACTIVE: begin
            if (target != sel_active)
               state_nxt = PENDING;
         end
         PENDING: begin
            if (target == sel_active) begin
               state_nxt = ACTIVE;
            end else if (idle_cnt == IDLE_MAX && idle_ok) begin
               // The target may have moved while pending; whatever it is now wins.
               state_nxt = SWITCH;
               sel_nxt   = target;
            end
         end
         SWITCH:  state_nxt = ACTIVE;
         default: state_nxt = ACTIVE;
      endcase
   end

   // Outputs are registered from the next-state view so routing and state change together.
   assign sel_oh_nxt  = NUM_PORTS'(1) << sel_nxt;
   assign tx_nxt      = (state_nxt == SWITCH) ? '1 : (~sel_oh_nxt | {NUM_PORTS{core_tx}});
   assign core_rx_nxt = (state_nxt == SWITCH) ? 1'b1 : rxs[sel_nxt];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_active <= '0;
         rx_en      <= NUM_PORTS'(1);
         tx_out     <= '1;
         core_rx    <= 1'b1;
         switching  <= 1'b0;
      end else begin
         sel_active <= sel_nxt;
         rx_en      <= sel_oh_nxt;
         tx_out     <= tx_nxt;
         core_rx    <= core_rx_nxt;
         switching  <= (state_nxt != ACTIVE);
      end
   end

endmodule

// File: tb/tb_serial_port_router.sv
// Scoreboard bench for serial_port_router: a window-based reference model predicts
// every registered output per clock; a monitor compares them after each edge.
module tb_serial_port_router;
   localparam int NP   = 3;
   localparam int SW   = 2;
   localparam int IDLE = 16;
   localparam int CW   = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [SW-1:0] sel_req = '0;
   logic [NP-1:0] rx_in = '1;
   logic          core_tx = 1'b1;
   logic [NP-1:0] tx_out, rx_en;
   logic          core_rx, switching;
   logic [SW-1:0] sel_active;

   serial_port_router #(.NUM_PORTS(NP), .SEL_W(SW), .SYNC_STAGES(2),
                        .IDLE_CYCLES(IDLE), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .sel_req(sel_req), .rx_in(rx_in), .tx_out(tx_out),
      .rx_en(rx_en), .core_tx(core_tx), .core_rx(core_rx), .sel_active(sel_active),
      .switching(switching));

   always #5 clk = ~clk;

   typedef struct {
      int            tag;
      logic [SW-1:0] sel;
      logic [NP-1:0] en;
      logic [NP-1:0] tx;
      logic          crx;
      logic          swg;
   } exp_t;

   exp_t          sb[$];
   int            edge_cnt = 0;
   int            checks = 0;
   int            errors = 0;
   int            chg_edge = -1;
   logic [SW-1:0] prev_sel = '0;

   // Input history of the current reset session, indexed by clock cycle.
   logic [NP-1:0] h_rx[$];
   logic          h_tx[$];
   logic [SW-1:0] h_req[$];
   int            m_act, m_pstart;
   bit            m_pend, m_swprev;

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] want, input int tag);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s edge=%0d got=%0h exp=%0h", nm, tag, got, want);
      end
   endtask

   task automatic check_rng(input string nm, input int got, input int lo, input int hi);
      checks++;
      if (got < lo || got > hi) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d..%0d", nm, got, lo, hi);
      end
   endtask

   // Line value seen by the router logic at edge e: the pin value two cycles back through the synchroniser.
   function automatic logic [NP-1:0] rxs_pre(input int e);
      if (e - 3 >= 0) return h_rx[e-3];
      return '1;
   endfunction

   function automatic int tgt(input int e);
      int r;
      r = int'(h_req[e-1]);
      return (r < NP) ? r : m_act;
   endfunction

   // Switch allowed at edge e when the IDLE+1 samples ending at e all lie inside the pending period and are idle.
   function automatic bit window_ok(input int e);
      for (int j = e - IDLE; j <= e; j++) begin
         logic [NP-1:0] p;
         if (j < m_pstart + 1) return 1'b0;
         p = rxs_pre(j);
         if (!(p[m_act] && p[tgt(j)] && h_tx[j-1])) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic exp_t predict(input int e);
      exp_t          x;
      int            t;
      bit            forced;
      logic [NP-1:0] p;
      forced = 1'b0;
      p = rxs_pre(e);
      t = tgt(e);
      if (m_swprev) begin
         m_swprev = 1'b0;
      end else if (!m_pend) begin
         if (t != m_act) begin
            m_pend   = 1'b1;
            m_pstart = e;
         end
      end else if (t == m_act) begin
         m_pend = 1'b0;
      end else if (window_ok(e)) begin
         m_act    = t;
         m_pend   = 1'b0;
         m_swprev = 1'b1;
         forced   = 1'b1;
      end
      x.tag = 0;
      x.sel = SW'(m_act);
      x.en  = NP'(1) << m_act;
      x.tx  = '1;
      x.crx = 1'b1;
      x.swg = m_pend | forced;
      if (!forced) begin
         x.tx[m_act] = h_tx[e-1];
         x.crx       = p[m_act];
      end
      return x;
   endfunction

   task automatic step(input bit r, input logic [SW-1:0] q, input logic [NP-1:0] rx, input logic tx);
      exp_t x;
      @(negedge clk); #1;
      reset = r; sel_req = q; rx_in = rx; core_tx = tx;
      if (r) begin
         h_rx.delete(); h_tx.delete(); h_req.delete();
         m_act = 0; m_pend = 1'b0; m_swprev = 1'b0; m_pstart = 0;
         x.sel = '0; x.en = NP'(1); x.tx = '1; x.crx = 1'b1; x.swg = 1'b0;
      end else begin
         h_rx.push_back(rx); h_tx.push_back(tx); h_req.push_back(q);
         x = predict(h_rx.size());
      end
      x.tag = edge_cnt + 1;
      sb.push_back(x);
   endtask

   // Monitor: compare whatever expectation belongs to the edge just taken.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk); #2;
         if (sel_active != prev_sel) begin
            chg_edge = edge_cnt;
            prev_sel = sel_active;
         end
         while (sb.size() > 0 && sb[0].tag < edge_cnt) begin
            x = sb.pop_front();
            checks++; errors++;
            $display("FAIL missed_sample edge=%0d now=%0d", x.tag, edge_cnt);
         end
         if (sb.size() > 0 && sb[0].tag == edge_cnt) begin
            x = sb.pop_front();
            cmp("sel_active", 8'(sel_active), 8'(x.sel), x.tag);
            cmp("rx_en",      8'(rx_en),      8'(x.en),  x.tag);
            cmp("tx_out",     8'(tx_out),     8'(x.tx),  x.tag);
            cmp("core_rx",    8'(core_rx),    8'(x.crx), x.tag);
            cmp("switching",  8'(switching),  8'(x.swg), x.tag);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int            req_edge, low_edge, noise;
      logic [SW-1:0] q;
      logic [NP-1:0] rx;
      logic          tx;
      bit            r;
      req_edge = 0; low_edge = 0;

      // Reset values, rx latency, tx latency.
      repeat (3) step(1'b1, 2'd0, '1, 1'b1);
      repeat (4) step(1'b0, 2'd0, '1, 1'b1);
      repeat (3) step(1'b0, 2'd0, 3'b110, 1'b1);
      repeat (4) step(1'b0, 2'd0, '1, 1'b1);
      repeat (2) step(1'b0, 2'd0, '1, 1'b0);
      repeat (4) step(1'b0, 2'd0, '1, 1'b1);

      // Idle lines, switch 0 -> 2.
      chg_edge = -1;
      step(1'b0, 2'd2, '1, 1'b1);
      req_edge = edge_cnt + 1;
      repeat (24) step(1'b0, 2'd2, '1, 1'b1);
      check_rng("idle_switch_delay", chg_edge - req_edge, IDLE, IDLE + 2);

      // Traffic on core_tx holds the switch off until it stops.
      repeat (2) step(1'b1, 2'd0, '1, 1'b1);
      repeat (3) step(1'b0, 2'd0, '1, 1'b1);
      chg_edge = -1;
      for (int k = 0; k < 64; k++) begin
         tx = ((k / 8) % 2 == 0) ? 1'b0 : 1'b1;
         step(1'b0, 2'd1, '1, tx);
         if (!tx) low_edge = edge_cnt + 1;
      end
      check_rng("no_switch_under_traffic", chg_edge, -1, -1);
      repeat (24) step(1'b0, 2'd1, '1, 1'b1);
      check_rng("switch_after_traffic", chg_edge - low_edge, IDLE, IDLE + 2);

      // Request withdrawn after 5 clocks.
      repeat (2) step(1'b1, 2'd0, '1, 1'b1);
      repeat (3) step(1'b0, 2'd0, '1, 1'b1);
      chg_edge = -1;
      repeat (5) step(1'b0, 2'd1, '1, 1'b1);
      repeat (25) step(1'b0, 2'd0, '1, 1'b1);
      check_rng("withdraw_no_switch", chg_edge, -1, -1);

      // Invalid index ignored.
      repeat (25) step(1'b0, 2'd3, '1, 1'b1);
      check_rng("invalid_no_switch", chg_edge, -1, -1);

      // Reset mid-pending restarts the full idle wait.
      repeat (11) step(1'b0, 2'd2, '1, 1'b1);
      repeat (2) step(1'b1, 2'd2, '1, 1'b1);
      chg_edge = -1;
      step(1'b0, 2'd2, '1, 1'b1);
      req_edge = edge_cnt + 1;
      repeat (24) step(1'b0, 2'd2, '1, 1'b1);
      check_rng("post_reset_switch_delay", chg_edge - req_edge, IDLE, IDLE + 2);

      // Randomised segments: request, noise level and occasional reset.
      for (int seg = 0; seg < 24; seg++) begin
         q     = SW'($urandom_range(0, 3));
         noise = int'($urandom_range(0, 2));
         r     = ($urandom_range(0, 9) == 0);
         if (r) step(1'b1, q, '1, 1'b1);
         for (int k = 0; k < 40; k++) begin
            rx = '1;
            tx = 1'b1;
            if (noise > 0) begin
               for (int i = 0; i < NP; i++)
                  if ($urandom_range(0, (noise == 1) ? 30 : 5) == 0) rx[i] = 1'b0;
               if ($urandom_range(0, (noise == 1) ? 30 : 5) == 0) tx = 1'b0;
            end
            if ($urandom_range(0, 60) == 0) q = SW'($urandom_range(0, 3));
            step(1'b0, q, rx, tx);
         end
      end

      repeat (3) @(posedge clk);
      #3;
      check_rng("scoreboard_drained", sb.size(), 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
